// File: rtl/aes_pkg.sv
// Shared AES constants and types: state encoding, round count, Rcon table and S-box.
package aes_pkg;

  typedef logic [0:127] block_t;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
  } state_e;

  localparam int unsigned AES_NR = 10;

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Ascending outer dimension: the first byte of the literal is S-box entry 0.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Counter values outside 1..10 never reach the table.
  function automatic logic [7:0] rcon_get(logic [3:0] r);
    if (r >= 4'd1 && r <= 4'd10) begin
      return RCON[r];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-schedule bus between the requester/datapath and the expander.
// Optional round-key stream signals exist only with AES_KEY_EXPAND_STREAM_EN.
interface aes_key_expand_if;
  import aes_pkg::*;

  logic   start;
  block_t cipher_key;
  logic   busy;
  logic   done;
  logic   keys_valid;
  block_t main_key;
  block_t key_round_1, key_round_2, key_round_3, key_round_4, key_round_5;
  block_t key_round_6, key_round_7, key_round_8, key_round_9, key_round_10;
`ifdef AES_KEY_EXPAND_STREAM_EN
  logic       rk_valid;
  logic [3:0] rk_index;
  block_t     rk_data;
`endif

  modport master (
    output start, cipher_key,
    input  busy, done, keys_valid, main_key,
    input  key_round_1, key_round_2, key_round_3, key_round_4, key_round_5,
    input  key_round_6, key_round_7, key_round_8, key_round_9, key_round_10
`ifdef AES_KEY_EXPAND_STREAM_EN
    , input rk_valid, rk_index, rk_data
`endif
  );

  modport slave (
    input  start, cipher_key,
    output busy, done, keys_valid, main_key,
    output key_round_1, key_round_2, key_round_3, key_round_4, key_round_5,
    output key_round_6, key_round_7, key_round_8, key_round_9, key_round_10
`ifdef AES_KEY_EXPAND_STREAM_EN
    , output rk_valid, rk_index, rk_data
`endif
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box byte lookup; shared with the encryption rounds.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock after a start request.
// Optional feature macro AES_KEY_EXPAND_STREAM_EN adds the rk_valid/rk_index/rk_data stream.
module aes_key_expand
  import aes_pkg::*;
(
  input logic             clk,
  input logic             reset,
  aes_key_expand_if.slave bus
);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  block_t     work_q, work_d;
  block_t     main_key_q, main_key_d;
  block_t     rk_q [1:AES_NR];
  block_t     rk_d [1:AES_NR];
  logic       done_q, done_d;
  logic       valid_q, valid_d;

  logic [31:0] w3_rot, w3_sub, t_word;
  logic [31:0] w0_n, w1_n, w2_n, w3_n;
  block_t      next_key;

  assign w3_rot = {work_q[104:127], work_q[96:103]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .data_i(w3_rot[31-8*i -: 8]),
      .data_o(w3_sub[31-8*i -: 8])
    );
  end

  assign t_word   = w3_sub ^ {rcon_get(round_q), 24'h000000};
  assign w0_n     = work_q[0:31] ^ t_word;
  assign w1_n     = work_q[32:63] ^ w0_n;
  assign w2_n     = work_q[64:95] ^ w1_n;
  assign w3_n     = work_q[96:127] ^ w2_n;
  assign next_key = {w0_n, w1_n, w2_n, w3_n};

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    work_d     = work_q;
    main_key_d = main_key_q;
    rk_d       = rk_q;
    done_d     = 1'b0;
    // The schedule becomes valid the cycle after the done pulse.
    valid_d    = valid_q | done_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          main_key_d = bus.cipher_key;
          work_d     = bus.cipher_key;
          valid_d    = 1'b0;
          round_d    = 4'd1;
          state_d    = StExpand;
        end
      end
      StExpand: begin
        work_d  = next_key;
        round_d = round_q + 4'd1;
        for (int unsigned k = 1; k <= AES_NR; k++) begin
          if (round_q == 4'(k)) rk_d[k] = next_key;
        end
        if (round_q == 4'(AES_NR)) begin
          round_d = 4'd0;
          state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      round_q    <= '0;
      work_q     <= '0;
      main_key_q <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      for (int unsigned k = 1; k <= AES_NR; k++) rk_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      work_q     <= work_d;
      main_key_q <= main_key_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      rk_q       <= rk_d;
    end
  end

  assign bus.busy         = (state_q != StIdle);
  assign bus.done         = done_q;
  assign bus.keys_valid   = valid_q;
  assign bus.main_key     = main_key_q;
  assign bus.key_round_1  = rk_q[1];
  assign bus.key_round_2  = rk_q[2];
  assign bus.key_round_3  = rk_q[3];
  assign bus.key_round_4  = rk_q[4];
  assign bus.key_round_5  = rk_q[5];
  assign bus.key_round_6  = rk_q[6];
  assign bus.key_round_7  = rk_q[7];
  assign bus.key_round_8  = rk_q[8];
  assign bus.key_round_9  = rk_q[9];
  assign bus.key_round_10 = rk_q[10];

`ifdef AES_KEY_EXPAND_STREAM_EN
  logic       rk_valid_q, rk_valid_d;
  logic [3:0] rk_index_q, rk_index_d;
  block_t     rk_data_q, rk_data_d;

  always_comb begin
    rk_valid_d = (state_q == StExpand);
    rk_index_d = rk_index_q;
    rk_data_d  = rk_data_q;
    if (state_q == StExpand) begin
      rk_index_d = round_q;
      rk_data_d  = next_key;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rk_valid_q <= 1'b0;
      rk_index_q <= '0;
      rk_data_q  <= '0;
    end else begin
      rk_valid_q <= rk_valid_d;
      rk_index_q <= rk_index_d;
      rk_data_q  <= rk_data_d;
    end
  end

  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_index = rk_index_q;
  assign bus.rk_data  = rk_data_q;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 A.1 and all-zero key schedules.
module tb_aes_key_expand;
  import aes_pkg::*;

  localparam block_t KeyA  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam block_t R1A   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam block_t R10A  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam block_t KeyZ  = 128'h0;
  localparam block_t R1Z   = 128'h62636363626363636263636362636363;
  localparam block_t R10Z  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  aes_key_expand_if bus ();

  aes_key_expand dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse at edge 0, then walk edges 1..12 checking the timing contract.
  task automatic expand_and_check(input string tag, input block_t key, input block_t r1,
                                  input block_t r10, input block_t prev_r10);
    int done_edge;
    int done_cnt;
    done_edge = -1;
    done_cnt  = 0;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.cipher_key = key;
    tick();
    bus.start = 1'b0;
    check_eq({tag, "_busy_e0"}, 128'(bus.busy), 128'd1);
    check_eq({tag, "_valid_e0"}, 128'(bus.keys_valid), 128'd0);
    check_eq({tag, "_main_key"}, bus.main_key, key);
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (bus.done) begin
        done_cnt++;
        done_edge = e;
      end
      if (e == 1) check_eq({tag, "_kr1"}, bus.key_round_1, r1);
      if (e == 5) check_eq({tag, "_kr10_hold"}, bus.key_round_10, prev_r10);
      if (e == 10) begin
        check_eq({tag, "_kr10"}, bus.key_round_10, r10);
        check_eq({tag, "_busy_e10"}, 128'(bus.busy), 128'd1);
      end
      if (e == 11) begin
        check_eq({tag, "_busy_e11"}, 128'(bus.busy), 128'd0);
        check_eq({tag, "_valid_e11"}, 128'(bus.keys_valid), 128'd0);
      end
      if (e == 12) check_eq({tag, "_valid_e12"}, 128'(bus.keys_valid), 128'd1);
`ifdef AES_KEY_EXPAND_STREAM_EN
      if (e <= 10) begin
        check_eq({tag, "_rk_valid"}, 128'(bus.rk_valid), 128'd1);
        check_eq({tag, "_rk_index"}, 128'(bus.rk_index), 128'(e));
      end
      if (e == 1) check_eq({tag, "_rk_data1"}, bus.rk_data, r1);
      if (e == 10) check_eq({tag, "_rk_data10"}, bus.rk_data, r10);
      if (e >= 11) check_eq({tag, "_rk_valid_off"}, 128'(bus.rk_valid), 128'd0);
`endif
    end
    check_eq({tag, "_done_cnt"}, 128'(done_cnt), 128'd1);
    check_eq({tag, "_done_edge"}, 128'(done_edge), 128'd11);
  endtask

  initial begin
    int done_seen;
    bus.start      = 1'b0;
    bus.cipher_key = '0;

    // Reset state.
    tick();
    tick();
    check_eq("rst_busy", 128'(bus.busy), 128'd0);
    check_eq("rst_done", 128'(bus.done), 128'd0);
    check_eq("rst_valid", 128'(bus.keys_valid), 128'd0);
    check_eq("rst_main_key", bus.main_key, 128'd0);
    check_eq("rst_kr1", bus.key_round_1, 128'd0);
    check_eq("rst_kr10", bus.key_round_10, 128'd0);
    @(negedge clk);
    reset = 1'b1;

    // Idle with start low holds everything.
    tick();
    tick();
    check_eq("idle_busy", 128'(bus.busy), 128'd0);

    expand_and_check("a1", KeyA, R1A, R10A, 128'd0);
    expand_and_check("zero", KeyZ, R1Z, R10Z, R10A);

    // Start held high; key switches to zero mid-run and is only used for the next run.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.cipher_key = KeyA;
    tick();
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 5) bus.cipher_key = KeyZ;
      if (e == 10) check_eq("held_kr10_a", bus.key_round_10, R10A);
      if (e == 11) check_eq("held_main_a", bus.main_key, KeyA);
      if (e == 12) begin
        check_eq("held_valid_e12", 128'(bus.keys_valid), 128'd0);
        check_eq("held_busy_e12", 128'(bus.busy), 128'd1);
        check_eq("held_main_b", bus.main_key, KeyZ);
      end
    end
    bus.start = 1'b0;
    for (int e = 1; e <= 12; e++) tick();
    check_eq("held_kr1_b", bus.key_round_1, R1Z);
    check_eq("held_kr10_b", bus.key_round_10, R10Z);
    check_eq("held_valid_b", 128'(bus.keys_valid), 128'd1);

    // Asynchronous reset at edge 6 aborts without a done pulse.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.cipher_key = KeyA;
    tick();
    bus.start = 1'b0;
    for (int e = 1; e <= 6; e++) tick();
    reset = 1'b0;
    #1;
    check_eq("abort_busy", 128'(bus.busy), 128'd0);
    check_eq("abort_main", bus.main_key, 128'd0);
    check_eq("abort_kr1", bus.key_round_1, 128'd0);
    check_eq("abort_kr10", bus.key_round_10, 128'd0);
    check_eq("abort_valid", 128'(bus.keys_valid), 128'd0);
    done_seen = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (bus.done) done_seen++;
    end
    check_eq("abort_no_done", 128'(done_seen), 128'd0);
    @(negedge clk);
    reset = 1'b1;
    expand_and_check("restart", KeyA, R1A, R10A, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key schedule sitting directly upstream of the encryption datapath. It latches the 128-bit cipher key on a start request and derives one round key per clock. Round keys 1..10 are held in registers that drive the datapath's `key_round_1`..`key_round_10` inputs, with `main_key` passed through for the initial AddRoundKey. A `keys_valid` level tells the datapath when the whole schedule is stable.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `start` input 1: request expansion of `cipher_key`; sampled only in IDLE.
- `cipher_key` input [0:127]: key; bit 0 = MSB of byte 0 (FIPS-197 order).
- `busy` output 1: high while expansion is in progress.
- `done` output 1: one-cycle pulse when round key 10 is written.
- `keys_valid` output 1: all outputs hold a complete schedule for `main_key`.
- `main_key` output [0:127]: registered copy of latched `cipher_key` (round key 0).
- `key_round_1` .. `key_round_10` output [0:127] each: registered round keys.

## Operation
- States: IDLE, EXPAND, DONE.
- IDLE, `start`=1: capture `cipher_key` into `main_key` and the working word register. Clear `keys_valid`. Set round counter r=1. Go to EXPAND.
- IDLE, `start`=0: hold everything.
- EXPAND: compute the next round key from the working key w[0..3]:
  - t = SubWord(RotWord(w3)) XOR {Rcon[r],00,00,00}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - Write the result to `key_round_r` and to the working register, then r = r+1.
  - After writing r=10, go to DONE.
- DONE (one cycle): `done`=1, set `keys_valid`, go to IDLE.
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36. Counter is 4 bits; values 0 and 11..15 are never used and must not index the table.
- `start` while `busy` or in DONE: ignored, no queuing.
- Round key registers for rounds not yet rewritten keep their old values during expansion. Consumers rely only on `keys_valid`.
- SubWord uses four combinational S-box lookups on the 32-bit word.

## Timing
- Edge 0 is the edge that samples `start`=1 in IDLE.
- `busy` is high from after edge 0 through the DONE cycle, i.e. edges 0..11.
- `key_round_k` is updated at edge k, for k=1..10.
- `done` is high for exactly one cycle, between edge 11 and edge 12.
- `keys_valid` rises at edge 12 and stays high until the next accepted `start`, which clears it at that edge.
- Start-to-`keys_valid` latency is 12 cycles. Back-to-back: a new `start` can be accepted at edge 12 at the earliest.
- Reset values: all outputs 0, state IDLE, r=0. Reset mid-expansion aborts immediately, with no `done`; a fresh `start` is required.
- The critical path is one S-box plus 5 XOR levels per cycle. No combinational path from inputs to outputs.

## Configuration
- Macro: `AES_KEY_EXPAND_STREAM_EN`.
- Defined: adds three outputs, all driven as each round key is written and reset to 0:
  - `rk_valid` (1 bit): one-cycle strobe at edges 1..10.
  - `rk_index` (4 bits): 1..10.
  - `rk_data` ([0:127]): the round key just written.
- Not defined: those ports do not exist. Behaviour of the remaining ports is identical either way.

## Structure
- Shared package `aes_pkg`, holding:
  - state encoding (IDLE/EXPAND/DONE);
  - `AES_NR = 10`;
  - the Rcon constant table (index 1..10);
  - the 256-entry S-box constant;
  - a 128-bit block type.
- Sub-module `aes_sbox`: combinational 8-bit lookup, instantiated four times for SubWord. The same module is reused by the encryption rounds.

## Test plan
- FIPS-197 A.1: `cipher_key`=2b7e151628aed2a6abf7158809cf4f3c, start pulse.
  - `key_round_1`=a0fafe1788542cb123a339392a6c7605.
  - `key_round_10`=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` one cycle at edge 11; `keys_valid` from edge 12.
- All-zero key:
  - `key_round_1`=62636363626363636263636362636363.
  - `key_round_10`=b4ef5bcb3e92e21123e951cf6f8f188e.
- `start` held high continuously with key A, then key changed to B at edge 5:
  - schedule completes for A only; a second expansion begins at edge 12 using B;
  - `keys_valid` drops at edge 12.
- Assert `reset` at edge 6: all outputs 0 asynchronously, no `done`; restart yields the correct A.1 keys.
- With `AES_KEY_EXPAND_STREAM_EN`: `rk_valid` high exactly 10 cycles, `rk_index` 1..10 in order, and each `rk_data` equals the corresponding `key_round_k`.
- Chain into the encryption datapath with A.1 key and plaintext 3243f6a8885a308d313198a2e0370734, launched after `keys_valid`: ciphertext 3925841d02dc09fbdc118597196a0b32.
